// File: rtl/post_log_controller.sv
// post_log_controller
//   Captures port-80h POST codes into a 256-entry log and drives a
//   seven-segment display. A debounced push-button selects the view:
//   a short press enters REVIEW or steps to the next entry, and a long
//   press returns to LIVE. The log stops at 256 entries and does not wrap.
//   After that, further codes are dropped and the sticky Overflow flag is set.
//
//   Optional build macro: POST_AUTOSCROLL_EN. When it is defined, REVIEW
//   advances to the next entry every AUTOSCROLL_CYCLES cycles. The
//   default build leaves this out.
//
// Ports
//   Clock         in   system clock, all state on the rising edge
//   nReset        in   asynchronous active-low reset
//   CodeValid     in   one-cycle strobe qualifying CodeData
//   CodeData      in   8-bit POST code
//   Button        in   raw asynchronous push-button, active high
//   DisplayData   out  code shown on the display (registered)
//   DisplayIndex  out  log index shown (registered)
//   Reviewing     out  high in REVIEW
//   Empty         out  high while the log holds no entries
//   Overflow      out  sticky: a code was dropped because the log was full
//   Count         out  number of stored entries, 0..256
module post_log_controller #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 1000000,
    parameter int AUTOSCROLL_CYCLES = 25000000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       CodeValid,
    input  logic [7:0] CodeData,
    input  logic       Button,
    output logic [7:0] DisplayData,
    output logic [7:0] DisplayIndex,
    output logic       Reviewing,
    output logic       Empty,
    output logic       Overflow,
    output logic [8:0] Count
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic {LIVE = 1'b0, REVIEW = 1'b1} state_t;

    // ---------------- button synchronizer and debouncer ----------------
    logic             btn_meta_reg, btn_sync_reg;
    logic             deb_level_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             deb_diff, deb_accept, fall_event;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
        end else begin
            btn_meta_reg <= Button;
            btn_sync_reg <= btn_meta_reg;
        end
    end

    // The counter tracks consecutive samples that disagree with the accepted
    // level. Any sample that agrees restarts the run.
    assign deb_diff   = (btn_sync_reg != deb_level_reg);
    assign deb_accept = deb_diff && (deb_cnt_reg == DEB_LAST);
    assign fall_event = deb_accept && deb_level_reg;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            deb_cnt_reg   <= '0;
            deb_level_reg <= 1'b0;
        end else begin
            if (!deb_diff || deb_accept)
                deb_cnt_reg <= '0;
            else
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            if (deb_accept)
                deb_level_reg <= ~deb_level_reg;
        end
    end

    // ---------------- short / long press classification ----------------
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              long_done_reg;
    logic              short_press_reg, long_press_reg;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            hold_cnt_reg    <= '0;
            long_done_reg   <= 1'b0;
            short_press_reg <= 1'b0;
            long_press_reg  <= 1'b0;
        end else begin
            // A release that follows a long press produces no pulse.
            short_press_reg <= fall_event && !long_done_reg;
            long_press_reg  <= 1'b0;
            if (fall_event || !deb_level_reg) begin
                hold_cnt_reg  <= '0;
                long_done_reg <= 1'b0;
            end else if (!long_done_reg) begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    long_press_reg <= 1'b1;
                    long_done_reg  <= 1'b1;
                    hold_cnt_reg   <= '0;
                end else begin
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                end
            end
        end
    end

    // ---------------- log buffer ----------------
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr_reg;
    logic [8:0] count_reg;
    logic       overflow_reg;
    logic       wr_en;

    // Count never exceeds 256, so bit 8 alone marks a full log.
    assign wr_en = CodeValid && !count_reg[8];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_reg   <= 8'd0;
            count_reg    <= 9'd0;
            overflow_reg <= 1'b0;
        end else if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 8'd1;
            count_reg  <= count_reg + 9'd1;
        end else if (CodeValid) begin
            overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en)
            mem[wr_ptr_reg] <= CodeData;
    end

    // ---------------- view FSM ----------------
    state_t     state_reg, state_next;
    logic [7:0] rd_idx_reg, rd_idx_next;
    logic       advance, at_last;

    // The wrap test uses the Count register value from before this edge.
    // A write on the same edge therefore does not move the wrap point yet.
    assign at_last = ({1'b0, rd_idx_reg} == (count_reg - 9'd1));

`ifdef POST_AUTOSCROLL_EN
    localparam int AS_W = $clog2(AUTOSCROLL_CYCLES + 1);
    localparam logic [AS_W-1:0] AS_LAST = AS_W'(AUTOSCROLL_CYCLES - 1);
    logic [AS_W-1:0] scroll_cnt_reg;
    logic            scroll_tick;

    assign scroll_tick = (state_reg == REVIEW) && (scroll_cnt_reg == AS_LAST);

    // The counter stays at zero in LIVE. Counting therefore starts fresh on
    // entry to REVIEW, and each short press restarts the period.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            scroll_cnt_reg <= '0;
        else if (state_reg != REVIEW || short_press_reg || scroll_tick)
            scroll_cnt_reg <= '0;
        else
            scroll_cnt_reg <= scroll_cnt_reg + 1'b1;
    end

    assign advance = short_press_reg || scroll_tick;
`else
    assign advance = short_press_reg;
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_reg  <= LIVE;
            rd_idx_reg <= 8'd0;
        end else begin
            state_reg  <= state_next;
            rd_idx_reg <= rd_idx_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rd_idx_next = rd_idx_reg;
        case (state_reg)
            LIVE: begin
                if (short_press_reg && (count_reg != 9'd0)) begin
                    state_next  = REVIEW;
                    rd_idx_next = 8'd0;
                end
            end
            REVIEW: begin
                if (long_press_reg)
                    state_next = LIVE;
                else if (advance)
                    rd_idx_next = at_last ? 8'd0 : rd_idx_reg + 8'd1;
            end
            default: state_next = LIVE;
        endcase
    end

    // ---------------- display path ----------------
    logic [7:0] rd_addr;
    logic [7:0] ram_q_reg;
    logic [7:0] disp_idx_reg;
    logic       show_zero_reg;
    logic       live_empty;

    assign live_empty = (state_reg == LIVE) && (count_reg == 9'd0);
    assign rd_addr    = (state_reg == REVIEW) ? rd_idx_reg : (wr_ptr_reg - 8'd1);

    // Registered RAM read with no reset. The read always observes writes
    // from earlier edges. The display therefore updates one cycle after
    // the index change or the write.
    always_ff @(posedge Clock) begin
        ram_q_reg <= mem[rd_addr];
    end

    // The blanking flag is reset asynchronously. It hides the non-reset RAM
    // output, so the display reads zero as soon as reset is asserted.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            show_zero_reg <= 1'b1;
            disp_idx_reg  <= 8'd0;
        end else begin
            show_zero_reg <= live_empty;
            disp_idx_reg  <= live_empty ? 8'd0 : rd_addr;
        end
    end

    assign DisplayData  = show_zero_reg ? 8'h00 : ram_q_reg;
    assign DisplayIndex = disp_idx_reg;
    assign Reviewing    = (state_reg == REVIEW);
    assign Empty        = (count_reg == 9'd0);
    assign Overflow     = overflow_reg;
    assign Count        = count_reg;

endmodule

// File: tb/tb_post_log_controller.sv
module tb_post_log_controller;

    localparam int DEB = 4;
    localparam int LP  = 20;
    localparam int AS  = 16;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic       CodeValid = 1'b0;
    logic [7:0] CodeData = 8'h00;
    logic       Button = 1'b0;
    logic [7:0] DisplayData;
    logic [7:0] DisplayIndex;
    logic       Reviewing;
    logic       Empty;
    logic       Overflow;
    logic [8:0] Count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 Clock = ~Clock;

    post_log_controller #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LP),
        .AUTOSCROLL_CYCLES(AS)
    ) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .CodeValid   (CodeValid),
        .CodeData    (CodeData),
        .Button      (Button),
        .DisplayData (DisplayData),
        .DisplayIndex(DisplayIndex),
        .Reviewing   (Reviewing),
        .Empty       (Empty),
        .Overflow    (Overflow),
        .Count       (Count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic write_code(input logic [7:0] d);
        CodeValid = 1'b1;
        CodeData  = d;
        tick(1);
        CodeValid = 1'b0;
        $display("write code %h -> count %0d overflow %b", d, Count, Overflow);
    endtask

    // Hold Button for n cycles, release it, then let the release settle.
    task automatic press(input int n);
        Button = 1'b1;
        tick(n);
        Button = 1'b0;
        tick(20);
        $display("press %0d cycles -> reviewing %b index %0d data %h", n, Reviewing, DisplayIndex, DisplayData);
    endtask

    task automatic do_reset;
        nReset = 1'b0;
        tick(2);
        nReset = 1'b1;
        tick(2);
        $display("reset pulse");
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        tick(3);
        total_cnt++; if (Reviewing !== 1'b0) $display("FAIL rst_reviewing: got %b exp 0", Reviewing); else pass_cnt++;
        total_cnt++; if (Empty !== 1'b1) $display("FAIL rst_empty: got %b exp 1", Empty); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'h00) $display("FAIL rst_data: got %h exp 00", DisplayData); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'h00) $display("FAIL rst_index: got %h exp 00", DisplayIndex); else pass_cnt++;
        total_cnt++; if (Count !== 9'd0) $display("FAIL rst_count: got %0d exp 0", Count); else pass_cnt++;
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL rst_overflow: got %b exp 0", Overflow); else pass_cnt++;
        nReset = 1'b1;
        tick(3);
        total_cnt++; if (DisplayData !== 8'h00) $display("FAIL idle_empty_data: got %h exp 00", DisplayData); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'h00) $display("FAIL idle_empty_index: got %h exp 00", DisplayIndex); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_live_write;
        write_code(8'h11);
        write_code(8'h22);
        tick(2);
        write_code(8'h33);
        // The write edge has just passed. The display still shows the old entry.
        total_cnt++; if (DisplayData !== 8'h22) $display("FAIL latency_old: got %h exp 22", DisplayData); else pass_cnt++;
        tick(1);
        total_cnt++; if (DisplayData !== 8'h33) $display("FAIL latency_new: got %h exp 33", DisplayData); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'd2) $display("FAIL live_index: got %0d exp 2", DisplayIndex); else pass_cnt++;
        total_cnt++; if (Count !== 9'd3) $display("FAIL live_count: got %0d exp 3", Count); else pass_cnt++;
        total_cnt++; if (Empty !== 1'b0) $display("FAIL live_empty: got %b exp 0", Empty); else pass_cnt++;
    endtask

    task automatic test_review_scroll;
        logic [7:0] exp_d [3];
        logic [7:0] exp_i [3];
        exp_d = '{8'h22, 8'h33, 8'h11};
        exp_i = '{8'd1, 8'd2, 8'd0};
        press(10);
        total_cnt++; if (Reviewing !== 1'b1) $display("FAIL enter_review: got %b exp 1", Reviewing); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'h11) $display("FAIL review_first_data: got %h exp 11", DisplayData); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'd0) $display("FAIL review_first_index: got %0d exp 0", DisplayIndex); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            press(10);
            total_cnt++; if (DisplayData !== exp_d[k]) $display("FAIL scroll_data_%0d: got %h exp %h", k, DisplayData, exp_d[k]); else pass_cnt++;
            total_cnt++; if (DisplayIndex !== exp_i[k]) $display("FAIL scroll_index_%0d: got %0d exp %0d", k, DisplayIndex, exp_i[k]); else pass_cnt++;
        end
    endtask

    task automatic test_long_press;
        Button = 1'b1;
        tick(28);
        total_cnt++; if (Reviewing !== 1'b0) $display("FAIL long_while_held: got %b exp 0", Reviewing); else pass_cnt++;
        tick(2);
        Button = 1'b0;
        tick(20);
        $display("long press 30 cycles -> reviewing %b data %h", Reviewing, DisplayData);
        total_cnt++; if (Reviewing !== 1'b0) $display("FAIL long_no_short_on_release: got %b exp 0", Reviewing); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'h33) $display("FAIL long_live_data: got %h exp 33", DisplayData); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'd2) $display("FAIL long_live_index: got %0d exp 2", DisplayIndex); else pass_cnt++;
    endtask

    task automatic test_glitch;
        Button = 1'b1;
        tick(2);
        Button = 1'b0;
        tick(20);
        $display("glitch 2 cycles -> reviewing %b", Reviewing);
        total_cnt++; if (Reviewing !== 1'b0) $display("FAIL glitch_state: got %b exp 0", Reviewing); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'd2) $display("FAIL glitch_index: got %0d exp 2", DisplayIndex); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        write_code(8'h11);
        write_code(8'h22);
        press(10);
        press(10);
        total_cnt++; if (DisplayIndex !== 8'd1) $display("FAIL b2b_pre_index: got %0d exp 1", DisplayIndex); else pass_cnt++;
        // Align the write with the cycle in which the short-press pulse is acted on:
        // release + 2 sync + 4 debounce, then the FSM edge.
        Button = 1'b1;
        tick(10);
        Button = 1'b0;
        tick(6);
        CodeValid = 1'b1;
        CodeData  = 8'h44;
        tick(1);
        CodeValid = 1'b0;
        tick(12);
        $display("short press with write 44 -> index %0d count %0d", DisplayIndex, Count);
        total_cnt++; if (Count !== 9'd3) $display("FAIL b2b_count: got %0d exp 3", Count); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'd0) $display("FAIL b2b_wrap_prewrite: got %0d exp 0", DisplayIndex); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'h11) $display("FAIL b2b_wrap_data: got %h exp 11", DisplayData); else pass_cnt++;
        press(10);
        press(10);
        total_cnt++; if (DisplayData !== 8'h44) $display("FAIL review_write_reach: got %h exp 44", DisplayData); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'd2) $display("FAIL review_write_index: got %0d exp 2", DisplayIndex); else pass_cnt++;
    endtask

    task automatic test_reset_in_review;
        #3;
        nReset = 1'b0;
        #1;
        $display("reset asserted in review");
        total_cnt++; if (Reviewing !== 1'b0) $display("FAIL async_rst_state: got %b exp 0", Reviewing); else pass_cnt++;
        total_cnt++; if (Empty !== 1'b1) $display("FAIL async_rst_empty: got %b exp 1", Empty); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'h00) $display("FAIL async_rst_data: got %h exp 00", DisplayData); else pass_cnt++;
        total_cnt++; if (Count !== 9'd0) $display("FAIL async_rst_count: got %0d exp 0", Count); else pass_cnt++;
        tick(2);
        nReset = 1'b1;
        tick(3);
        total_cnt++; if (DisplayData !== 8'h00) $display("FAIL post_rst_data: got %h exp 00", DisplayData); else pass_cnt++;
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 256; i++)
            write_code(8'(i) ^ 8'h5A);
        write_code(8'hEE);
        tick(2);
        total_cnt++; if (Count !== 9'd256) $display("FAIL ovf_count: got %0d exp 256", Count); else pass_cnt++;
        total_cnt++; if (Overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", Overflow); else pass_cnt++;
        total_cnt++; if (DisplayIndex !== 8'd255) $display("FAIL ovf_index: got %0d exp 255", DisplayIndex); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'hA5) $display("FAIL ovf_last_data: got %h exp a5", DisplayData); else pass_cnt++;
        press(10);
        total_cnt++; if (DisplayData !== 8'h5A) $display("FAIL ovf_no_overwrite: got %h exp 5a", DisplayData); else pass_cnt++;
        Button = 1'b1;
        tick(30);
        Button = 1'b0;
        tick(20);
        write_code(8'h77);
        tick(2);
        total_cnt++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", Overflow); else pass_cnt++;
        total_cnt++; if (Reviewing !== 1'b0) $display("FAIL ovf_back_live: got %b exp 0", Reviewing); else pass_cnt++;
        do_reset();
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL ovf_cleared: got %b exp 0", Overflow); else pass_cnt++;
    endtask

    task automatic test_autoscroll;
        do_reset();
        write_code(8'h11);
        write_code(8'h22);
        write_code(8'h33);
        press(10);
        total_cnt++; if (DisplayIndex !== 8'd0) $display("FAIL as_start_index: got %0d exp 0", DisplayIndex); else pass_cnt++;
`ifdef POST_AUTOSCROLL_EN
        tick(4);
        $display("autoscroll step -> index %0d data %h", DisplayIndex, DisplayData);
        total_cnt++; if (DisplayIndex !== 8'd1) $display("FAIL as_step1: got %0d exp 1", DisplayIndex); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'h22) $display("FAIL as_data1: got %h exp 22", DisplayData); else pass_cnt++;
        tick(16);
        $display("autoscroll step -> index %0d data %h", DisplayIndex, DisplayData);
        total_cnt++; if (DisplayIndex !== 8'd2) $display("FAIL as_step2: got %0d exp 2", DisplayIndex); else pass_cnt++;
        tick(16);
        $display("autoscroll step -> index %0d data %h", DisplayIndex, DisplayData);
        total_cnt++; if (DisplayIndex !== 8'd0) $display("FAIL as_step3: got %0d exp 0", DisplayIndex); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'h11) $display("FAIL as_data3: got %h exp 11", DisplayData); else pass_cnt++;
`else
        tick(36);
        $display("idle in review -> index %0d data %h", DisplayIndex, DisplayData);
        total_cnt++; if (DisplayIndex !== 8'd0) $display("FAIL no_autoscroll_index: got %0d exp 0", DisplayIndex); else pass_cnt++;
        total_cnt++; if (DisplayData !== 8'h11) $display("FAIL no_autoscroll_data: got %h exp 11", DisplayData); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_live_write();
        test_review_scroll();
        test_long_press();
        test_glitch();
        test_back_to_back();
        test_reset_in_review();
        test_overflow();
        test_autoscroll();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
